// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: default widths, reset PC, fetch buffer depth
// and the occupancy encoding used by the fetch stage.
package cpu_pkg;

   localparam int unsigned DEFAULT_WIDTH      = 32;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 12;
   localparam int unsigned DEFAULT_RESET_PC   = 0;
   localparam int unsigned FETCH_BUF_DEPTH    = 2;

   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_ONE   = 2'd1;
   localparam occ_t OCC_FULL  = 2'd2;

   // True when a new request cannot overrun the buffer: occ + inflight - pop < 2.
   function automatic logic has_room(occ_t occ, logic inflight, logic pop);
      return ({1'b0, occ} + {2'b00, inflight}) < ({2'b00, pop} + 3'd2);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between program memory and decode.
// Head outputs come straight from the storage registers.
module fetch_buffer
   import cpu_pkg::*;
#(
   parameter int unsigned           WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_pc,
   input  logic [WIDTH-1:0]      push_instr,
   input  logic                  pop,
   input  logic                  clear,
   output occ_t                  occ,
   output logic [ADDR_WIDTH-1:0] head_pc,
   output logic [WIDTH-1:0]      head_instr
);

   logic [ADDR_WIDTH-1:0] pc_q    [FETCH_BUF_DEPTH];
   logic [WIDTH-1:0]      instr_q [FETCH_BUF_DEPTH];
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr;
   occ_t                  occ_q, occ_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      // Tail sits one past the head whenever the buffer is non-empty.
      wr_ptr   = rd_ptr_q ^ (occ_q != OCC_EMPTY);
      if (clear) begin
         occ_d = OCC_EMPTY;
      end else begin
         if (pop) rd_ptr_d = ~rd_ptr_q;
         if (push && !pop) begin
            occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
         end else if (pop && !push) begin
            occ_d = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= '{default: RESET_PC};
         instr_q  <= '{default: '0};
         rd_ptr_q <= 1'b0;
         occ_q    <= OCC_EMPTY;
      end else begin
         if (push && !clear) begin
            pc_q[wr_ptr]    <= push_pc;
            instr_q[wr_ptr] <= push_instr;
         end
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign occ        = occ_q;
   assign head_pc    = pc_q[rd_ptr_q];
   assign head_instr = instr_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, in-flight request tracking, issue/redirect control and a
// two-entry fetch buffer feeding decode over valid/ready.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned           WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  imem_en,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0]      imem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_instr,
   output logic [ADDR_WIDTH-1:0] out_pc
);

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                  inflight_q, inflight_d;
   logic                  redirect, push, pop;
   occ_t                  occ;

   always_comb begin
      redirect      = reset & redirect_valid;
      out_valid     = (occ != OCC_EMPTY) & ~redirect_valid;
      pop           = out_valid & out_ready;
      // Data returning during a redirect belongs to the abandoned path.
      push          = inflight_q & ~redirect;
      imem_en       = reset & (redirect_valid | has_room(occ, inflight_q, pop));
      imem_addr     = redirect ? redirect_addr : fetch_pc_q;
      inflight_d    = imem_en;
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      if (redirect) begin
         fetch_pc_d    = redirect_addr + PC_ONE;
         inflight_pc_d = redirect_addr;
      end else if (imem_en) begin
         fetch_pc_d    = fetch_pc_q + PC_ONE;
         inflight_pc_d = fetch_pc_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= RESET_PC;
         inflight_q    <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
      end
   end

   fetch_buffer #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_fetch_buffer (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_pc    (inflight_pc_q),
      .push_instr (imem_rdata),
      .pop        (pop),
      .clear      (redirect),
      .occ        (occ),
      .head_pc    (out_pc),
      .head_instr (out_instr)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit; a stream scoreboard
// expects consecutive PCs from the last reset or redirect target.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [11:0] redirect_addr;
   logic        imem_en;
   logic [11:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [11:0] out_pc;

   logic        w_redirect_valid = 1'b0;
   logic [11:0] w_redirect_addr  = 12'h000;
   logic        w_out_ready      = 1'b1;
   logic        w_imem_en;
   logic [11:0] w_imem_addr;
   logic [31:0] w_imem_rdata;
   logic        w_out_valid;
   logic [31:0] w_out_instr;
   logic [11:0] w_out_pc;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_pops   = 0;
   int          pops_before;
   logic [11:0] exp_pc   = 12'h000;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   instr_fetch_unit #(
      .RESET_PC (12'hFFE)
   ) dut_w (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (w_redirect_valid),
      .redirect_addr  (w_redirect_addr),
      .imem_en        (w_imem_en),
      .imem_addr      (w_imem_addr),
      .imem_rdata     (w_imem_rdata),
      .out_valid      (w_out_valid),
      .out_ready      (w_out_ready),
      .out_instr      (w_out_instr),
      .out_pc         (w_out_pc)
   );

   function automatic logic [31:0] mem_word(input logic [11:0] a);
      return 32'h1000_0000 + {20'd0, a};
   endfunction

   always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);
   always @(posedge clk) if (w_imem_en) w_imem_rdata <= mem_word(w_imem_addr);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Sample at the falling edge, update the stream model, then advance one cycle.
   task automatic cyc();
      @(negedge clk);
      if (reset && redirect_valid) begin
         chk("redir_void", 64'(out_valid), 64'(0));
         exp_pc = redirect_addr;
      end else if (out_valid && out_ready) begin
         chk("sb_pc", 64'(out_pc), 64'(exp_pc));
         chk("sb_instr", 64'(out_instr), 64'(mem_word(exp_pc)));
         exp_pc = exp_pc + 12'd1;
         n_pops++;
      end
      @(posedge clk);
      #1;
   endtask

   // Leaves the caller at the start of C0 (first cycle with reset released).
   task automatic do_reset();
      reset = 1'b0;
      redirect_valid = 1'b0;
      exp_pc = 12'h000;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 12'h000;
      out_ready      = 1'b1;
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_imem_en", 64'(imem_en), 64'(0));
      chk("rst_imem_addr", 64'(imem_addr), 64'(0));
      chk("rst_out_instr", 64'(out_instr), 64'(0));
      chk("rst_out_pc", 64'(out_pc), 64'(0));
      chk("rst_w_out_pc", 64'(w_out_pc), 64'(12'hFFE));
      chk("rst_w_imem_addr", 64'(w_imem_addr), 64'(12'hFFE));

      // Reset release and free-running stream
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("c0_imem_en", 64'(imem_en), 64'(1));
      chk("c0_imem_addr", 64'(imem_addr), 64'(0));
      chk("c0_out_valid", 64'(out_valid), 64'(0));
      chk("c0_w_imem_addr", 64'(w_imem_addr), 64'(12'hFFE));
      cyc();
      chk("c1_out_valid", 64'(out_valid), 64'(0));
      cyc();
      chk("c2_out_pc", 64'(out_pc), 64'(0));
      for (int k = 0; k < 8; k++) begin
         logic [11:0] wpc;
         wpc = 12'hFFE + 12'(k);
         chk("stream_valid", 64'(out_valid), 64'(1));
         chk("w_valid", 64'(w_out_valid), 64'(1));
         chk("w_pc", 64'(w_out_pc), 64'(wpc));
         chk("w_instr", 64'(w_out_instr), 64'(mem_word(wpc)));
         cyc();
      end

      // Back-pressure from C0 until the buffer settles full
      do_reset();
      out_ready = 1'b0;
      repeat (6) cyc();
      chk("stall_imem_en", 64'(imem_en), 64'(0));
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_head_pc", 64'(out_pc), 64'(0));
      out_ready = 1'b1;
      #1;
      chk("resume_imem_en", 64'(imem_en), 64'(1));
      chk("resume_imem_addr", 64'(imem_addr), 64'(2));
      for (int k = 0; k < 4; k++) begin
         chk("resume_nogap", 64'(out_valid), 64'(1));
         cyc();
      end
      chk("resume_exp_pc", 64'(exp_pc), 64'(4));

      // Redirect while the buffer is full
      out_ready = 1'b0;
      repeat (4) cyc();
      chk("full_imem_en", 64'(imem_en), 64'(0));
      chk("full_valid", 64'(out_valid), 64'(1));
      redirect_valid = 1'b1;
      redirect_addr  = 12'h040;
      out_ready      = 1'b1;
      #1;
      chk("r0_valid", 64'(out_valid), 64'(0));
      chk("r0_imem_en", 64'(imem_en), 64'(1));
      chk("r0_imem_addr", 64'(imem_addr), 64'(12'h040));
      cyc();
      redirect_valid = 1'b0;
      chk("r1_valid", 64'(out_valid), 64'(0));
      cyc();
      chk("r2_valid", 64'(out_valid), 64'(1));
      chk("r2_pc", 64'(out_pc), 64'(12'h040));
      repeat (4) cyc();

      // Redirect held for three cycles with changing targets
      for (int i = 0; i < 3; i++) begin
         redirect_valid = 1'b1;
         redirect_addr  = 12'(256 * (i + 1));
         #1;
         chk("hold_imem_addr", 64'(imem_addr), 64'(redirect_addr));
         cyc();
      end
      redirect_valid = 1'b0;
      cyc();
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_pc", 64'(out_pc), 64'(12'h300));
      repeat (3) cyc();

      // Toggling out_ready, redirect lands on a would-be pop
      for (int i = 0; i < 12; i++) begin
         out_ready = (i % 2 == 0);
         if (i == 6) begin
            #1;
            chk("pre_redir_valid", 64'(out_valid), 64'(1));
            redirect_valid = 1'b1;
            redirect_addr  = 12'h010;
            #1;
            chk("toggle_redir_valid", 64'(out_valid), 64'(0));
         end else begin
            redirect_valid = 1'b0;
         end
         cyc();
      end
      chk("toggle_exp_pc", 64'(exp_pc), 64'(12'h012));

      // Random traffic
      redirect_valid = 1'b0;
      pops_before = n_pops;
      for (int i = 0; i < 400; i++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_addr  = 12'($urandom);
         cyc();
      end
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) cyc();
      chk("random_live", 64'(out_valid), 64'(1));
      chk("random_progress", 64'(n_pops - pops_before > 100), 64'(1));

      // Asynchronous reset between edges with a full buffer
      out_ready = 1'b0;
      repeat (4) cyc();
      chk("pre_async_en", 64'(imem_en), 64'(0));
      chk("pre_async_valid", 64'(out_valid), 64'(1));
      #2;
      reset = 1'b0;
      #1;
      chk("async_valid", 64'(out_valid), 64'(0));
      chk("async_imem_en", 64'(imem_en), 64'(0));
      chk("async_imem_addr", 64'(imem_addr), 64'(0));
      chk("async_out_pc", 64'(out_pc), 64'(0));
      chk("async_out_instr", 64'(out_instr), 64'(0));
      @(posedge clk);
      #1;
      exp_pc = 12'h000;
      reset  = 1'b1;
      #1;
      chk("rel_c0_imem_en", 64'(imem_en), 64'(1));
      chk("rel_c0_imem_addr", 64'(imem_addr), 64'(0));
      out_ready = 1'b1;
      cyc();
      cyc();
      chk("rel_c2_valid", 64'(out_valid), 64'(1));
      chk("rel_c2_pc", 64'(out_pc), 64'(0));
      repeat (4) cyc();
      chk("rel_exp_pc", 64'(exp_pc), 64'(4));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
